// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for the RAM port A arbiter.
//   req_id_t  : which requester an access belongs to
//   ret_tag_t : {valid, id} tag travelling down the read-return pipe
//   MODE_*    : values for the arbiter's RR_MODE parameter
package ram_arb_pkg;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } ret_tag_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: one requester's view of RAM port A.
//   req/wren/addr/data : request, held stable by the requester until gnt
//   gnt                : access accepted at this edge
//   rvalid/q           : read data return, valid for exactly one cycle
// modport master = requester side, modport slave = arbiter side.
interface ram_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          wren;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] q;

  modport master (output req, wren, addr, data, input gnt, rvalid, q);
  modport slave  (input req, wren, addr, data, output gnt, rvalid, q);
endinterface

// File: rtl/ram_arb_ret_pipe.sv
// ram_arb_ret_pipe: DEPTH-stage shift register of read-return tags.
//   clock_i : clock
//   clr_i   : synchronous clear (drops every in-flight tag)
//   tag_i   : tag loaded every cycle (valid=0 for writes / idle)
//   tag_o   : tag aligned with the RAM's read data
module ram_arb_ret_pipe
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clock_i,
  input  logic     clr_i,
  input  ret_tag_t tag_i,
  output ret_tag_t tag_o
);

  ret_tag_t pipe_q [DEPTH];

  always_ff @(posedge clock_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares RAM port A between the CPU and the DMA/blit engine.
//   clock_i        : RAM port A clock
//   reset_n_i      : synchronous active-low reset
//   cpu_if, dma_if : requester handshakes (slave modport)
//   ram_address_o  : to RAM address_a (CPU address when idle)
//   ram_data_o     : to RAM data_a
//   ram_wren_o     : to RAM wren_a
//   ram_q_i        : from RAM q_a, returned to whichever requester issued the read
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int READ_LATENCY = 2,
  parameter int RR_MODE      = 1,
  parameter int MAX_WAIT     = 4
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  ram_port_arbiter_if.slave cpu_if,
  ram_port_arbiter_if.slave dma_if,
  output logic [AW-1:0]     ram_address_o,
  output logic [DW-1:0]     ram_data_o,
  output logic              ram_wren_o,
  input  logic [DW-1:0]     ram_q_i
);

  localparam int            WW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  req_id_t       last_grant_q, last_grant_d;
  logic          pick_dma;
  logic          cpu_gnt, dma_gnt;
  ret_tag_t      ret_in, ret_out;

  // Decide who would win if both asked; a lone requester always wins.
  always_comb begin
    pick_dma = 1'b0;
    if (dma_if.req && !cpu_if.req) begin
      pick_dma = 1'b1;
    end else if (dma_if.req && cpu_if.req) begin
      if (RR_MODE == MODE_FIXED) pick_dma = (MAX_WAIT > 0) && (wait_cnt_q == WAIT_MAX);
      else                       pick_dma = (last_grant_q == REQ_CPU);
    end
  end

  // Reset gates grants combinationally so nothing reaches the RAM while held low.
  assign cpu_gnt = reset_n_i & cpu_if.req & ~pick_dma;
  assign dma_gnt = reset_n_i & dma_if.req &  pick_dma;

  assign cpu_if.gnt = cpu_gnt;
  assign dma_if.gnt = dma_gnt;

  assign ram_address_o = dma_gnt ? dma_if.addr : cpu_if.addr;
  assign ram_data_o    = dma_gnt ? dma_if.data : cpu_if.data;
  assign ram_wren_o    = (cpu_gnt & cpu_if.wren) | (dma_gnt & dma_if.wren);

  always_comb begin
    last_grant_d = last_grant_q;
    if (cpu_gnt)      last_grant_d = REQ_CPU;
    else if (dma_gnt) last_grant_d = REQ_DMA;

    wait_cnt_d = wait_cnt_q;
    if (!dma_if.req || dma_gnt)     wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;

    ret_in.valid = (cpu_gnt & ~cpu_if.wren) | (dma_gnt & ~dma_if.wren);
    ret_in.id    = dma_gnt ? REQ_DMA : REQ_CPU;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      last_grant_q <= REQ_DMA;  // CPU wins the first round-robin conflict
      wait_cnt_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  ram_arb_ret_pipe #(.DEPTH(READ_LATENCY)) u_ret_pipe (
    .clock_i (clock_i),
    .clr_i   (~reset_n_i),
    .tag_i   (ret_in),
    .tag_o   (ret_out)
  );

  assign cpu_if.rvalid = ret_out.valid && (ret_out.id == REQ_CPU);
  assign dma_if.rvalid = ret_out.valid && (ret_out.id == REQ_DMA);
  assign cpu_if.q      = ram_q_i;
  assign dma_if.q      = ram_q_i;

endmodule
